// File: rtl/btn_led_out_pkg.sv
// Shared constants for the LED blink path: FSM state encoding and phase-counter sizing.
// Latency: n/a. This package holds only constants and elaboration-time functions.
// Backpressure: n/a. Optional feature macro PEND_OVF_EN is consumed by btn_led_out and btn_led_out_if.
package btn_led_out_pkg;

  // FSM state encoding, kept as plain constants so older tools and dumps read the same codes
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  // Ceiling log2, used to size counters from their maximum count
  function automatic int clog2_f(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Phase counter holds at most max(ON_TICKS, GAP_TICKS)-1; never narrower than one bit
  function automatic int phase_w(input int on_ticks, input int gap_ticks);
    int m;
    int w;
    m = (on_ticks > gap_ticks) ? on_ticks : gap_ticks;
    w = clog2_f(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_led_out_if.sv
// Event/LED bundle between control logic and the LED blinker.
// Latency: n/a. This file contains wiring only.
// Backpressure: none. Events are fire-and-forget pulses; the overflow pair exists only with PEND_OVF_EN.
interface btn_led_out_if;

  logic i_trig;
  logic o_led;
  logic o_busy;
`ifdef PEND_OVF_EN
  logic o_ovf;
  logic i_ovf_clr;

  modport master (output i_trig, output i_ovf_clr, input o_led, input o_busy, input o_ovf);
  modport slave  (input i_trig, input i_ovf_clr, output o_led, output o_busy, output o_ovf);
`else
  modport master (output i_trig, input o_led, input o_busy);
  modport slave  (input i_trig, output o_led, output o_busy);
`endif

endinterface

// File: rtl/btn_led_out_tick_gen.sv
// Free-running 2^BIT_SIZE prescaler that emits a one-cycle tick when its count is all-ones.
// Latency: the tick follows 2^BIT_SIZE enabled cycles after a clear.
// Backpressure: none. The prescaler holds at zero while run is low and restarts on clr.
module btn_led_out_tick_gen #(
  parameter int BIT_SIZE = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  logic [BIT_SIZE-1:0] cnt;

  // Count only while running; a clear realigns the tick to the start of a phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !run) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = run && (cnt == '1);

endmodule

// File: rtl/btn_led_out.sv
// Turns single-cycle event pulses into visible LED blinks, queueing events that arrive mid-blink.
// Latency: o_led rises the cycle after i_trig is sampled in IDLE. Each blink is ON_TICKS ticks, then a GAP_TICKS-tick dark gap.
// Backpressure: none. Excess events saturate the pending counter and are dropped; with PEND_OVF_EN a sticky o_ovf records that.
module btn_led_out
  import btn_led_out_pkg::*;
#(
  parameter int BIT_SIZE  = 20,
  parameter int ON_TICKS  = 8,
  parameter int GAP_TICKS = 4,
  parameter int PEND_W    = 3
) (
  input  logic           clk,
  input  logic           i_rst_n,
  btn_led_out_if.slave   bus
);

  localparam int                PH_W     = phase_w(ON_TICKS, GAP_TICKS);
  localparam logic [PH_W-1:0]   ON_LOAD  = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0]   GAP_LOAD = PH_W'(GAP_TICKS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [PH_W-1:0]   phase;
  logic [PH_W-1:0]   phase_nxt;
  logic [PEND_W-1:0] pend;
  logic [PEND_W-1:0] pend_nxt;
  logic              trig;
  logic              run;
  logic              tick;
  logic              phase_end;
  logic              pend_sat;

  assign trig      = bus.i_trig;
  assign run       = (state != IDLE);
  assign phase_end = tick && (phase == '0);
  assign pend_sat  = (pend == PEND_MAX);

  // The prescaler restarts on every state change so each phase is a whole number of ticks
  btn_led_out_tick_gen #(
    .BIT_SIZE (BIT_SIZE)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (i_rst_n),
    .clr   (state_nxt != state),
    .run   (run),
    .tick  (tick)
  );

  // Next-state, phase and pending-queue decisions
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    pend_nxt  = pend;
    case (state)
      IDLE: begin
        // An idle trigger starts its own blink directly and is not queued
        if (trig) begin
          state_nxt = ON;
          phase_nxt = ON_LOAD;
        end
      end
      ON: begin
        if (trig && !pend_sat) begin
          pend_nxt = pend + 1'b1;
        end
        if (phase_end) begin
          state_nxt = GAP;
          phase_nxt = GAP_LOAD;
        end else if (tick) begin
          phase_nxt = phase - 1'b1;
        end
      end
      GAP: begin
        if (phase_end) begin
          if (trig) begin
            // A fresh trigger supplies the next blink itself, so the queue depth is unchanged
            state_nxt = ON;
            phase_nxt = ON_LOAD;
          end else if (pend != '0) begin
            state_nxt = ON;
            phase_nxt = ON_LOAD;
            pend_nxt  = pend - 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          if (trig && !pend_sat) begin
            pend_nxt = pend + 1'b1;
          end
          if (tick) begin
            phase_nxt = phase - 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, phase and pending registers; reset discards any queued events
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      phase <= '0;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      pend  <= pend_nxt;
    end
  end

  // Outputs decode straight from the state flops so the LED pin is glitch-free
  assign bus.o_led  = (state == ON);
  assign bus.o_busy = (state != IDLE);

`ifdef PEND_OVF_EN
  logic ovf;

  // Sticky flag: a trigger seen while busy with the queue full sets it; set beats a same-cycle clear
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf <= 1'b0;
    end else if (trig && run && pend_sat) begin
      ovf <= 1'b1;
    end else if (bus.i_ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  assign bus.o_ovf = ovf;
`endif

endmodule
